simd_seq: RTL and testbench
===========================

# simd_seq

Sequencing front-end for the 4-lane SIMD adder/multiplier array. It accepts a vector command (opcode, beat count) and streams that many operand beats into a `simd_arr` instance. Each lane-wise result is registered and delivered on a valid/ready result stream, with a last flag on the final beat. The block sits between the operand fetch logic and the writeback path; it turns the combinational array into a flow-controlled, pipelined unit.

## Interface
- `LANES`, 4: lanes per beat; fixed at 4 to match `simd_arr`.
- `OW`, 32: operand width per lane.
- `CNT_W`, 8: width of the command length field.

- `i_clk` in 1: clock.
- `i_rstn` in 1: reset, asynchronous and active-low.
- `i_cmd_valid` in 1: command offered.
- `o_cmd_ready` out 1: command accepted; high only in IDLE.
- `i_cmd_op` in 2: 00 add, 01 mul, 10 sub, 11 see Configuration.
- `i_cmd_len` in CNT_W: number of beats minus 1 (0 means 1 beat, 255 means 256 beats).
- `i_opd_valid` in 1: operand beat offered.
- `o_opd_ready` out 1: operand beat accepted.
- `i_opd_a` in LANES*OW: operand 1, with lane k at bits [k*OW +: OW].
- `i_opd_b` in LANES*OW: operand 2, same lane packing.
- `o_res_valid` out 1: result beat available.
- `i_res_ready` in 1: downstream accepts the result.
- `o_res` out LANES*OW: lane-wise result.
- `o_res_last` out 1: marks the final result beat of the command.
- `o_busy` out 1: high whenever the state is not IDLE.

## Operation
- A transfer fires on any stream when valid and ready are both high on a rising edge.
- The FSM has three states: IDLE, RUN, DRAIN.
  - IDLE to RUN: on a command fire. The block latches op into `op_q`, loads `beat_cnt` with len, and clears the accumulator.
  - RUN: each operand fire presents a and b to `simd_arr` with `op_q` and pushes the result into the 2-entry result FIFO.
    - `beat_cnt` decrements on each operand fire.
    - When a fire occurs with `beat_cnt`==0, the pushed beat is tagged last and the state moves to DRAIN.
  - DRAIN to IDLE: when the FIFO is empty, or when it holds exactly 1 entry and that entry pops this cycle.
- `o_opd_ready` = (state==RUN) && (fifo_count<2). It is derived from registered state only and has no combinational path from `i_res_ready`.
- FIFO behaviour:
  - Push and pop in the same cycle leave the count unchanged.
  - At count 2, no push is possible because ready is low.
  - `o_res`, `o_res_valid` and `o_res_last` come from the FIFO head.
- Arithmetic is per lane, modulo 2^OW. Products keep only the low OW bits. Subtraction is a−b and wraps on underflow. There is no carry between lanes.
- Operand beats offered outside RUN are ignored, and ready stays low.
- A command offered while not in IDLE stalls, because `o_cmd_ready` is low.

## Timing
- Latency: an operand fire on edge t makes the result visible with `o_res_valid`=1 after edge t, i.e. in the next cycle.
- Throughput: 1 beat per cycle while `i_res_ready` is held high.
- Command-to-first-operand: the command fires on edge t, and `o_opd_ready` can be high in the cycle after it.
- Back-to-back commands: the next command can fire in the cycle after DRAIN returns to IDLE.
- Reset values:
  - state is IDLE, so `o_cmd_ready`=1 and `o_busy`=0.
  - `o_opd_ready`=0, `o_res_valid`=0, `o_res_last`=0, `o_res`=0.
  - FIFO count, `beat_cnt`, `op_q` and the accumulator are all 0.
- Reset asserted mid-command aborts the command immediately. Buffered results are discarded, and no last beat is emitted.
- The valid-hold rule applies: once asserted, `o_res_valid` stays high and `o_res` stays stable until the beat fires.

## Configuration
- Macro `SIMD_SEQ_MAC_EN`.
- Defined: op 11 is multiply-accumulate.
  - Each operand fire updates acc[k] += a[k]*b[k], modulo 2^OW.
  - No per-beat results are produced.
  - On the last beat, the block pushes acc + a*b as a single beat tagged last.
  - Latency from the last operand fire to result valid is 1 cycle.
- Undefined: op 11 is passed through to `simd_arr` unchanged. The array treats it as subtract, so it behaves exactly as 10. The accumulator is not instantiated.

## Structure
- Package `simd_pkg` holds:
  - opcode localparams `OP_ADD`, `OP_MUL`, `OP_SUB`, `OP_MAC`;
  - state typedef `seq_state_t` (IDLE/RUN/DRAIN);
  - default `LANES` and `OW`.
- Sub-module `simd_res_fifo`: 2-entry FIFO of width LANES*OW+1 with push, pop, count, and head outputs.
- `simd_arr` is instantiated once, combinationally, between the operand inputs and the FIFO.

## Test plan
- Add, len=0: lane k of a = k+1, b = 10; result 0x…0B,0C,0D,0E arrives 1 cycle later with last=1; FSM returns to IDLE.
- Sub wrap, len=1: beat 0 a=0, b=1 gives 0xFFFFFFFF in every lane; beat 1 a=5, b=3 gives 2 with last on beat 1 only.
- Mul truncation: a=0x00010000, b=0x00010000 gives 0 in each lane; a=7, b=6 gives 42.
- Backpressure, len=3: hold `i_res_ready`=0. `o_opd_ready` drops after 2 fires. Release the stall; all 4 results arrive in order with no loss or duplication, and last is on the 4th.
- Reset mid-RUN: after 2 of 5 beats, pulse `i_rstn` low. All outputs take their reset values asynchronously; the next command runs cleanly.
- With `SIMD_SEQ_MAC_EN`: op 11, len=2, a=b=2 on every beat gives a single result of 12 per lane with last=1. Without the macro, the same stimulus gives three results of 0.

Source files
------------

// File: rtl/simd_pkg.sv
// simd_pkg
// Shared definitions for the SIMD sequencer slice: opcode encodings,
// the sequencer state type and default lane geometry.
package simd_pkg;

    localparam int DEF_LANES = 4;
    localparam int DEF_OW    = 32;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_MAC = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_t;

endpackage

// File: rtl/simd_arr.sv
// simd_arr
// Combinational 4-lane adder/multiplier array. Every lane is independent
// and wraps modulo 2^OW; products keep only the low OW bits.
// Ports:
//   op  - 00 add, 01 mul, 10 sub, 11 sub (array has no MAC of its own)
//   a,b - packed operands, lane k at [k*OW +: OW]
//   res - packed lane-wise result
module simd_arr
    import simd_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int OW    = DEF_OW
) (
    input  logic [1:0]          op,
    input  logic [LANES*OW-1:0] a,
    input  logic [LANES*OW-1:0] b,
    output logic [LANES*OW-1:0] res
);

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [OW-1:0] la;
            logic [OW-1:0] lb;
            logic [OW-1:0] lr;
            assign la = a[gi*OW +: OW];
            assign lb = b[gi*OW +: OW];
            always_comb begin
                lr = '0;
                case (op)
                    OP_ADD:  lr = la + lb;
                    OP_MUL:  lr = la * lb;
                    default: lr = la - lb;
                endcase
            end
            assign res[gi*OW +: OW] = lr;
        end
    endgenerate

endmodule

// File: rtl/simd_res_fifo.sv
// simd_res_fifo
// Two-entry result FIFO. Entry 0 is always the head, so the output is a
// plain register and holds still until it is popped.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   push, din  - write strobe and data (caller never pushes when full)
//   pop        - read strobe (ignored when empty)
//   count      - occupancy 0..2
//   head       - entry at the front of the queue (0 when reset)
module simd_res_fifo #(
    parameter int W = 129
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [1:0]   count,
    output logic [W-1:0] head
);

    logic [W-1:0] entry0;
    logic [W-1:0] entry1;
    logic         do_push;
    logic         do_pop;

    assign do_push = push && (count != 2'd2);
    assign do_pop  = pop && (count != 2'd0);
    assign head    = entry0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry0 <= '0;
            entry1 <= '0;
            count  <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0) entry0 <= din;
                    else               entry1 <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    count  <= count - 2'd1;
                end
                2'b11: begin
                    // With one entry the new beat becomes the head directly.
                    if (count == 2'd1) begin
                        entry0 <= din;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/simd_seq.sv
// simd_seq
// Sequencing front-end for the 4-lane SIMD array: accepts a vector command,
// streams len+1 operand beats through simd_arr and delivers the registered
// results on a valid/ready stream with a last flag.
// Optional feature: define SIMD_SEQ_MAC_EN to make op 11 a per-lane
// multiply-accumulate producing one result beat per command.
// Ports:
//   i_clk, i_rstn                          - clock, async active-low reset
//   i_cmd_valid/o_cmd_ready, i_cmd_op/len  - command stream
//   i_opd_valid/o_opd_ready, i_opd_a/b     - operand stream
//   o_res_valid/i_res_ready, o_res, o_res_last - result stream
//   o_busy                                 - state is not IDLE
module simd_seq
    import simd_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int OW    = DEF_OW,
    parameter int CNT_W = 8
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic [1:0]          i_cmd_op,
    input  logic [CNT_W-1:0]    i_cmd_len,
    input  logic                i_opd_valid,
    output logic                o_opd_ready,
    input  logic [LANES*OW-1:0] i_opd_a,
    input  logic [LANES*OW-1:0] i_opd_b,
    output logic                o_res_valid,
    input  logic                i_res_ready,
    output logic [LANES*OW-1:0] o_res,
    output logic                o_res_last,
    output logic                o_busy
);

    localparam int DW = LANES * OW;

    seq_state_t       state_reg;
    seq_state_t       state_next;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] beat_cnt;
    logic [1:0]       fifo_count;
    logic [DW:0]      fifo_head;

    logic             cmd_fire;
    logic             opd_fire;
    logic             res_pop;
    logic             last_beat;
    logic [1:0]       arr_op;
    logic [DW-1:0]    arr_res;
    logic             push;
    logic [DW-1:0]    push_data;

    assign o_cmd_ready = (state_reg == ST_IDLE);
    assign o_busy      = (state_reg != ST_IDLE);
    // Registered terms only: no path from i_res_ready.
    assign o_opd_ready = (state_reg == ST_RUN) && (fifo_count != 2'd2);
    assign o_res_valid = (fifo_count != 2'd0);
    assign o_res       = fifo_head[DW-1:0];
    assign o_res_last  = fifo_head[DW];

    assign cmd_fire  = i_cmd_valid && o_cmd_ready;
    assign opd_fire  = i_opd_valid && o_opd_ready;
    assign res_pop   = o_res_valid && i_res_ready;
    assign last_beat = (beat_cnt == '0);

`ifdef SIMD_SEQ_MAC_EN
    logic          is_mac;
    logic [DW-1:0] acc;
    logic [DW-1:0] acc_sum;

    assign is_mac = (op_q == OP_MAC);
    // MAC borrows the array's multiplier; the accumulate happens here.
    assign arr_op = is_mac ? OP_MUL : op_q;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_acc
            assign acc_sum[gi*OW +: OW] = acc[gi*OW +: OW] + arr_res[gi*OW +: OW];
        end
    endgenerate

    assign push      = opd_fire && (!is_mac || last_beat);
    assign push_data = is_mac ? acc_sum : arr_res;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)                acc <= '0;
        else if (cmd_fire)          acc <= '0;
        else if (opd_fire && is_mac) acc <= acc_sum;
    end
`else
    assign arr_op    = op_q;
    assign push      = opd_fire;
    assign push_data = arr_res;
`endif

    simd_arr #(.LANES(LANES), .OW(OW)) u_arr (
        .op  (arr_op),
        .a   (i_opd_a),
        .b   (i_opd_b),
        .res (arr_res)
    );

    simd_res_fifo #(.W(DW + 1)) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rstn),
        .push  (push),
        .din   ({last_beat, push_data}),
        .pop   (res_pop),
        .count (fifo_count),
        .head  (fifo_head)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (cmd_fire) state_next = ST_RUN;
            ST_RUN:   if (opd_fire && last_beat) state_next = ST_DRAIN;
            ST_DRAIN: if ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && res_pop))
                          state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg <= ST_IDLE;
            op_q      <= 2'd0;
            beat_cnt  <= '0;
        end else begin
            state_reg <= state_next;
            if (cmd_fire) begin
                op_q     <= i_cmd_op;
                beat_cnt <= i_cmd_len;
            end else if (opd_fire && !last_beat) begin
                beat_cnt <= beat_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_simd_seq.sv
module tb_simd_seq;

    logic         clk = 1'b0;
    logic         rstn;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [7:0]   cmd_len;
    logic         opd_valid;
    logic         opd_ready;
    logic [127:0] opd_a;
    logic [127:0] opd_b;
    logic         res_valid;
    logic         res_ready;
    logic [127:0] res;
    logic         res_last;
    logic         busy;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    simd_seq dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_op    (cmd_op),
        .i_cmd_len   (cmd_len),
        .i_opd_valid (opd_valid),
        .o_opd_ready (opd_ready),
        .i_opd_a     (opd_a),
        .i_opd_b     (opd_b),
        .o_res_valid (res_valid),
        .i_res_ready (res_ready),
        .o_res       (res),
        .o_res_last  (res_last),
        .o_busy      (busy)
    );

    function automatic logic [127:0] rep(input logic [31:0] x);
        return {4{x}};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [7:0] len);
        cmd_op    = op;
        cmd_len   = len;
        cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !cmd_ready; i++) tick();
        if (!cmd_ready) check("cmd_ready_timeout", {127'd0, cmd_ready}, 128'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic put_opd(input logic [127:0] a, input logic [127:0] b);
        opd_a     = a;
        opd_b     = b;
        opd_valid = 1'b1;
        for (int i = 0; i < 50 && !opd_ready; i++) tick();
        if (!opd_ready) check("opd_ready_timeout", {127'd0, opd_ready}, 128'd1);
        tick();
        opd_valid = 1'b0;
    endtask

    task automatic expect_res(input string tag, input logic [127:0] data, input logic last);
        $display("beat %s: valid=%0b res=%h last=%0b", tag, res_valid, res, res_last);
        check({tag, "_valid"}, {127'd0, res_valid}, 128'd1);
        check({tag, "_data"}, res, data);
        check({tag, "_last"}, {127'd0, res_last}, {127'd0, last});
    endtask

    initial begin
        rstn = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_len = 8'd0;
        opd_valid = 1'b0; opd_a = '0; opd_b = '0; res_ready = 1'b0;
        tick(); tick();

        // Reset state
        check("rst_cmd_ready", {127'd0, cmd_ready}, 128'd1);
        check("rst_busy",      {127'd0, busy},      128'd0);
        check("rst_opd_ready", {127'd0, opd_ready}, 128'd0);
        check("rst_res_valid", {127'd0, res_valid}, 128'd0);
        check("rst_res_last",  {127'd0, res_last},  128'd0);
        check("rst_res",       res,                 128'd0);
        rstn = 1'b1;
        tick();

        // Add, len=0
        res_ready = 1'b1;
        send_cmd(2'b00, 8'd0);
        check("add_busy",      {127'd0, busy},      128'd1);
        check("add_cmd_ready", {127'd0, cmd_ready}, 128'd0);
        check("add_opd_ready", {127'd0, opd_ready}, 128'd1);
        put_opd({32'd4, 32'd3, 32'd2, 32'd1}, rep(32'd10));
        expect_res("add", {32'h0E, 32'h0D, 32'h0C, 32'h0B}, 1'b1);
        tick();
        check("add_idle",     {127'd0, busy},      128'd0);
        check("add_no_valid", {127'd0, res_valid}, 128'd0);

        // Sub wrap, len=1
        send_cmd(2'b10, 8'd1);
        put_opd(rep(32'd0), rep(32'd1));
        expect_res("sub0", rep(32'hFFFF_FFFF), 1'b0);
        put_opd(rep(32'd5), rep(32'd3));
        expect_res("sub1", rep(32'd2), 1'b1);
        tick();
        check("sub_idle", {127'd0, busy}, 128'd0);

        // Mul truncation, len=1
        send_cmd(2'b01, 8'd1);
        put_opd(rep(32'h0001_0000), rep(32'h0001_0000));
        expect_res("mul0", rep(32'd0), 1'b0);
        put_opd(rep(32'd7), rep(32'd6));
        expect_res("mul1", rep(32'd42), 1'b1);
        tick();
        check("mul_idle", {127'd0, busy}, 128'd0);

        // Backpressure, len=3
        res_ready = 1'b0;
        send_cmd(2'b00, 8'd3);
        put_opd(rep(32'd0), rep(32'd100));
        put_opd(rep(32'd1), rep(32'd100));
        check("bp_opd_ready_low", {127'd0, opd_ready}, 128'd0);
        expect_res("bp_head0", rep(32'd100), 1'b0);
        tick(); tick();
        check("bp_opd_ready_held", {127'd0, opd_ready}, 128'd0);
        expect_res("bp_hold0", rep(32'd100), 1'b0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        expect_res("bp_b1", rep(32'd101), 1'b0);
        put_opd(rep(32'd2), rep(32'd100));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        expect_res("bp_b2", rep(32'd102), 1'b0);
        put_opd(rep(32'd3), rep(32'd100));
        expect_res("bp_b2_held", rep(32'd102), 1'b0);
        res_ready = 1'b1;
        tick();
        expect_res("bp_b3", rep(32'd103), 1'b1);
        tick();
        check("bp_empty", {127'd0, res_valid}, 128'd0);
        check("bp_idle",  {127'd0, busy},      128'd0);

        // Reset mid-RUN after 2 of 5 beats
        res_ready = 1'b0;
        send_cmd(2'b00, 8'd4);
        put_opd(rep(32'd1), rep(32'd1));
        put_opd(rep(32'd2), rep(32'd2));
        rstn = 1'b0;
        #1;
        check("mid_rst_busy",      {127'd0, busy},      128'd0);
        check("mid_rst_cmd_ready", {127'd0, cmd_ready}, 128'd1);
        check("mid_rst_opd_ready", {127'd0, opd_ready}, 128'd0);
        check("mid_rst_res_valid", {127'd0, res_valid}, 128'd0);
        check("mid_rst_res_last",  {127'd0, res_last},  128'd0);
        check("mid_rst_res",       res,                 128'd0);
        tick();
        rstn = 1'b1;
        tick();
        res_ready = 1'b1;
        send_cmd(2'b00, 8'd0);
        put_opd(rep(32'd5), rep(32'd6));
        expect_res("post_rst", rep(32'd11), 1'b1);
        tick();
        check("post_rst_idle", {127'd0, busy}, 128'd0);

        // Op 11, len=2, a=b=2
        send_cmd(2'b11, 8'd2);
`ifdef SIMD_SEQ_MAC_EN
        put_opd(rep(32'd2), rep(32'd2));
        check("mac_no_beat0", {127'd0, res_valid}, 128'd0);
        put_opd(rep(32'd2), rep(32'd2));
        check("mac_no_beat1", {127'd0, res_valid}, 128'd0);
        put_opd(rep(32'd2), rep(32'd2));
        expect_res("mac", rep(32'd12), 1'b1);
`else
        put_opd(rep(32'd2), rep(32'd2));
        expect_res("op3_b0", rep(32'd0), 1'b0);
        put_opd(rep(32'd2), rep(32'd2));
        expect_res("op3_b1", rep(32'd0), 1'b0);
        put_opd(rep(32'd2), rep(32'd2));
        expect_res("op3_b2", rep(32'd0), 1'b1);
`endif
        tick();
        check("op3_empty", {127'd0, res_valid}, 128'd0);
        check("op3_idle",  {127'd0, busy},      128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
